// File: rtl/gpi_bank_debounce.sv
// GPI bank back-end: IE gating, per-channel synchroniser, programmable debounce,
// edge pulses and sticky write-1-to-clear edge status with a combined interrupt.
module gpi_bank_debounce #(
    parameter int NCH         = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             CLK_I,
    input  logic             RSTN_I,
    input  logic [NCH-1:0]   PAD_DI_I,
    input  logic [NCH-1:0]   IE_I,
    input  logic [CNT_W-1:0] FILT_LEN_I,
    input  logic [NCH-1:0]   IRQ_RISE_EN_I,
    input  logic [NCH-1:0]   IRQ_FALL_EN_I,
    input  logic [NCH-1:0]   IRQ_CLR_I,
    output logic [NCH-1:0]   DI_O,
    output logic [NCH-1:0]   RISE_O,
    output logic [NCH-1:0]   FALL_O,
    output logic [NCH-1:0]   STAT_O,
    output logic             IRQ_O
);

    logic [SYNC_STAGES-1:0][NCH-1:0] r_sync;
    logic [NCH-1:0][CNT_W-1:0]       r_cnt;
    logic [NCH-1:0]                  r_di;
    logic [NCH-1:0]                  r_rise;
    logic [NCH-1:0]                  r_fall;
    logic [NCH-1:0]                  r_stat;

    logic [NCH-1:0] w_gin;
    logic [NCH-1:0] w_sync;
    logic [NCH-1:0] w_diff;
    logic [NCH-1:0] w_accept;
    logic [NCH-1:0] w_set;

    // Gating ahead of the synchroniser, so dropping IE is debounced like a real fall.
    assign w_gin  = PAD_DI_I & IE_I;
    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge CLK_I) begin
        if (!RSTN_I) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_gin};
        end
    end

    // The >= compare accepts at once if the length is lowered below a running count.
    always_comb begin
        w_diff   = '0;
        w_accept = '0;
        for (int i = 0; i < NCH; i++) begin
            w_diff[i]   = w_sync[i] ^ r_di[i];
            w_accept[i] = w_diff[i] && (r_cnt[i] >= FILT_LEN_I);
        end
    end

    always_ff @(posedge CLK_I) begin
        if (!RSTN_I) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!w_diff[i] || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (!RSTN_I) begin
            r_di   <= '0;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_di   <= r_di ^ w_accept;
            r_rise <= w_accept & w_sync;
            r_fall <= w_accept & ~w_sync;
        end
    end

    // A new edge event wins over a simultaneous clear.
    assign w_set = (r_rise & IRQ_RISE_EN_I) | (r_fall & IRQ_FALL_EN_I);

    always_ff @(posedge CLK_I) begin
        if (!RSTN_I) begin
            r_stat <= '0;
        end else begin
            r_stat <= w_set | (r_stat & ~IRQ_CLR_I);
        end
    end

    assign DI_O   = r_di;
    assign RISE_O = r_rise;
    assign FALL_O = r_fall;
    assign STAT_O = r_stat;
    assign IRQ_O  = |r_stat;

endmodule

// File: tb/tb_gpi_bank_debounce.sv
// Bench for gpi_bank_debounce: directed latency/boundary scenarios plus random
// traffic, every cycle scored against a history-window reference model.
module tb_gpi_bank_debounce;

    localparam int NCH = 8;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic [NCH-1:0] di;
        logic [NCH-1:0] rise;
        logic [NCH-1:0] fall;
        logic [NCH-1:0] stat;
        logic           irq;
    } exp_t;

    logic             CLK_I;
    logic             RSTN_I;
    logic [NCH-1:0]   PAD_DI_I;
    logic [NCH-1:0]   IE_I;
    logic [CNT_W-1:0] FILT_LEN_I;
    logic [NCH-1:0]   IRQ_RISE_EN_I;
    logic [NCH-1:0]   IRQ_FALL_EN_I;
    logic [NCH-1:0]   IRQ_CLR_I;
    logic [NCH-1:0]   DI_O;
    logic [NCH-1:0]   RISE_O;
    logic [NCH-1:0]   FALL_O;
    logic [NCH-1:0]   STAT_O;
    logic             IRQ_O;

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    bit armed = 0;

    exp_t           expQ[$];
    logic [NCH-1:0] mPipe[$];
    logic [NCH-1:0] mHist[$];
    logic [NCH-1:0] mDi, mRise, mFall, mStat;

    gpi_bank_debounce #(
        .NCH(NCH), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)
    ) dut (
        .CLK_I(CLK_I), .RSTN_I(RSTN_I), .PAD_DI_I(PAD_DI_I), .IE_I(IE_I),
        .FILT_LEN_I(FILT_LEN_I), .IRQ_RISE_EN_I(IRQ_RISE_EN_I),
        .IRQ_FALL_EN_I(IRQ_FALL_EN_I), .IRQ_CLR_I(IRQ_CLR_I),
        .DI_O(DI_O), .RISE_O(RISE_O), .FALL_O(FALL_O), .STAT_O(STAT_O), .IRQ_O(IRQ_O)
    );

    initial begin
        CLK_I = 1'b0;
        forever #5 CLK_I = ~CLK_I;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "[TB] timeout");
    end

    // Reference: a level is accepted once the synchronised history has differed
    // from the current debounced level for the last FILT_LEN_I+1 samples.
    task automatic modelStep();
        logic [NCH-1:0] s, nRise, nFall, nStat;
        int run;
        exp_t e;
        if (!RSTN_I) begin
            mPipe.delete();
            for (int i = 0; i < SYNC_STAGES; i++) mPipe.push_back('0);
            mHist.delete();
            mDi = '0; mRise = '0; mFall = '0; mStat = '0;
        end else begin
            s = mPipe.pop_front();
            mPipe.push_back(PAD_DI_I & IE_I);
            mHist.push_back(s);
            if (mHist.size() > 300) void'(mHist.pop_front());
            nStat = (mRise & IRQ_RISE_EN_I) | (mFall & IRQ_FALL_EN_I) | (mStat & ~IRQ_CLR_I);
            nRise = '0;
            nFall = '0;
            for (int ch = 0; ch < NCH; ch++) begin
                run = 0;
                for (int k = mHist.size() - 1; k >= 0; k--) begin
                    if (mHist[k][ch] != mDi[ch]) run++;
                    else break;
                end
                if (run >= int'(FILT_LEN_I) + 1) begin
                    if (mDi[ch]) nFall[ch] = 1'b1;
                    else nRise[ch] = 1'b1;
                end
            end
            mDi   = mDi ^ (nRise | nFall);
            mRise = nRise;
            mFall = nFall;
            mStat = nStat;
        end
        e.di = mDi; e.rise = mRise; e.fall = mFall; e.stat = mStat; e.irq = |mStat;
        expQ.push_back(e);
        armed = 1'b1;
    endtask

    task automatic applyStimulus(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK_I);
            modelStep();
            @(posedge CLK_I);
            #1;
            cycle++;
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
        end
    endtask

    task automatic doReset();
        RSTN_I = 1'b0;
        applyStimulus(2);
        RSTN_I = 1'b1;
    endtask

    // Scoreboard monitor: one expected record per clock edge.
    initial begin
        exp_t e, got;
        forever begin
            @(posedge CLK_I);
            #1;
            if (armed) begin
                got = '{di: DI_O, rise: RISE_O, fall: FALL_O, stat: STAT_O, irq: IRQ_O};
                tests++;
                if (expQ.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL scoreboard underflow at cycle %0d: got output, expected queued record", cycle);
                end else begin
                    e = expQ.pop_front();
                    if (got !== e) begin
                        fails++;
                        $display("[TB] FAIL scoreboard cycle %0d: got di=%h rise=%h fall=%h stat=%h irq=%b, expected di=%h rise=%h fall=%h stat=%h irq=%b",
                                 cycle, got.di, got.rise, got.fall, got.stat, got.irq,
                                 e.di, e.rise, e.fall, e.stat, e.irq);
                    end
                end
            end
        end
    end

    initial begin
        RSTN_I = 1'b0; PAD_DI_I = '1; IE_I = '1; FILT_LEN_I = 8'd3;
        IRQ_RISE_EN_I = '0; IRQ_FALL_EN_I = '0; IRQ_CLR_I = '0;

        // Reset with pads high, then qualification after release.
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("T1 reset outputs", {DI_O, RISE_O, FALL_O, STAT_O, IRQ_O}, 64'd0);
        end
        RSTN_I = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus();
            checkOutput("T1 di early", DI_O, 64'h00);
        end
        applyStimulus();
        checkOutput("T1 di at 6", DI_O, 64'hff);
        checkOutput("T1 rise at 6", RISE_O, 64'hff);
        applyStimulus();
        checkOutput("T1 rise single", RISE_O, 64'h00);

        // Glitch of four synchronised cycles is rejected, five is accepted.
        PAD_DI_I = '0; FILT_LEN_I = 8'd4;
        doReset();
        PAD_DI_I[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 4) PAD_DI_I[0] = 1'b0;
            applyStimulus();
            checkOutput("T2 glitch di", DI_O[0], 64'd0);
            checkOutput("T2 glitch rise", RISE_O[0], 64'd0);
        end
        PAD_DI_I[0] = 1'b1;
        applyStimulus(6);
        checkOutput("T2 di before 7", DI_O[0], 64'd0);
        applyStimulus();
        checkOutput("T2 di at 7", DI_O[0], 64'd1);

        // Zero filter length: three edges from pad to level.
        PAD_DI_I = '0; FILT_LEN_I = 8'd0;
        doReset();
        PAD_DI_I[3] = 1'b1;
        applyStimulus(2);
        checkOutput("T3 di at 2", DI_O[3], 64'd0);
        applyStimulus();
        checkOutput("T3 di at 3", DI_O[3], 64'd1);
        checkOutput("T3 rise at 3", RISE_O[3], 64'd1);
        applyStimulus();
        checkOutput("T3 rise at 4", RISE_O[3], 64'd0);

        // Dropping IE on a high channel is a debounced fall.
        PAD_DI_I = '0; FILT_LEN_I = 8'd2;
        doReset();
        PAD_DI_I[1] = 1'b1;
        applyStimulus(10);
        checkOutput("T4 di settled", DI_O[1], 64'd1);
        IE_I[1] = 1'b0;
        applyStimulus(4);
        checkOutput("T4 di at 4", DI_O[1], 64'd1);
        checkOutput("T4 fall at 4", FALL_O[1], 64'd0);
        applyStimulus();
        checkOutput("T4 fall at 5", FALL_O[1], 64'd1);
        checkOutput("T4 di at 5", DI_O[1], 64'd0);
        for (int i = 0; i < 20; i++) begin
            PAD_DI_I[1] = 1'($urandom_range(0, 1));
            applyStimulus();
            checkOutput("T4 gated di", DI_O[1], 64'd0);
        end
        IE_I = '1;

        // Status set, set-beats-clear, clear alone.
        PAD_DI_I = '0; FILT_LEN_I = 8'd0; IRQ_RISE_EN_I = 8'h04;
        doReset();
        PAD_DI_I[2] = 1'b1;
        applyStimulus(3);
        checkOutput("T5 rise", RISE_O[2], 64'd1);
        checkOutput("T5 stat before", STAT_O[2], 64'd0);
        applyStimulus();
        checkOutput("T5 stat set", STAT_O[2], 64'd1);
        checkOutput("T5 irq set", IRQ_O, 64'd1);
        PAD_DI_I[2] = 1'b0;
        applyStimulus(5);
        PAD_DI_I[2] = 1'b1;
        applyStimulus(3);
        checkOutput("T5 rise again", RISE_O[2], 64'd1);
        IRQ_CLR_I = 8'h04;
        applyStimulus();
        checkOutput("T5 set beats clear", STAT_O[2], 64'd1);
        applyStimulus();
        checkOutput("T5 clear stat", STAT_O[2], 64'd0);
        checkOutput("T5 clear irq", IRQ_O, 64'd0);
        IRQ_CLR_I = '0; IRQ_RISE_EN_I = '0;

        // Reset in the middle of a long count discards it.
        PAD_DI_I = '0; FILT_LEN_I = 8'd10;
        doReset();
        PAD_DI_I[5] = 1'b1;
        applyStimulus(8);
        checkOutput("T6 di mid count", DI_O[5], 64'd0);
        RSTN_I = 1'b0;
        applyStimulus();
        checkOutput("T6 reset outputs", {DI_O, RISE_O, FALL_O, STAT_O, IRQ_O}, 64'd0);
        RSTN_I = 1'b1;
        applyStimulus(12);
        checkOutput("T6 di at 12", DI_O[5], 64'd0);
        applyStimulus();
        checkOutput("T6 di at 13", DI_O[5], 64'd1);
        checkOutput("T6 rise at 13", RISE_O[5], 64'd1);

        // Random traffic: glitchy pads, IE drops, enables, clears, length changes, resets.
        for (int c = 0; c < 2500; c++) begin
            if (c % 250 == 0) FILT_LEN_I = CNT_W'($urandom_range(0, 6));
            if (c % 50 == 0) begin
                IRQ_RISE_EN_I = NCH'($urandom());
                IRQ_FALL_EN_I = NCH'($urandom());
            end
            for (int ch = 0; ch < NCH; ch++) begin
                if ($urandom_range(0, 5) == 0) PAD_DI_I[ch] = ~PAD_DI_I[ch];
                if ($urandom_range(0, 39) == 0) IE_I[ch] = ~IE_I[ch];
            end
            IRQ_CLR_I = ($urandom_range(0, 7) == 0) ? NCH'($urandom()) : '0;
            RSTN_I = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            applyStimulus();
        end

        @(negedge CLK_I);
        armed = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
